// File: rtl/stroke_line_rasterizer.sv
// Turns a stream of cursor samples into VGA pixel writes, joining consecutive
// pen-down samples with Bresenham lines (one pixel per clock).
module stroke_line_rasterizer #(
    parameter int SCREEN_WIDTH  = 320,
    parameter int SCREEN_HEIGHT = 240
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       pos_valid,
    input  logic [8:0] pos_x,
    input  logic [7:0] pos_y,
    input  logic       pen_down,
    input  logic [8:0] pen_color,
    output logic       pos_ready,
    output logic [8:0] vga_x,
    output logic [7:0] vga_y,
    output logic [8:0] vga_color,
    output logic       vga_write,
    output logic       busy
);

    // state  | meaning
    // IDLE   | waiting for a cursor sample; single-pixel writes are issued from here
    // LINE   | stepping from the last point towards the newest point, one write per clock

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LINE = 1'b1
    } state_t;

    localparam logic [8:0] MAX_X = 9'(SCREEN_WIDTH - 1);
    localparam logic [7:0] MAX_Y = 8'(SCREEN_HEIGHT - 1);

    state_t r_state;
    state_t w_state_next;

    logic [8:0]        r_last_x;
    logic [7:0]        r_last_y;
    logic              r_last_valid;
    logic [8:0]        r_vga_x;
    logic [7:0]        r_vga_y;
    logic [8:0]        r_vga_color;
    logic              r_vga_write;
    logic [9:0]        r_adx;
    logic [9:0]        r_ady;
    logic signed [1:0] r_sx;
    logic signed [1:0] r_sy;
    logic signed [11:0] r_err;

    logic              w_accept;
    logic [8:0]        w_clamp_x;
    logic [7:0]        w_clamp_y;
    logic              w_start_line;
    logic              w_same_point;
    logic              w_at_end;
    logic signed [9:0] w_dx;
    logic signed [9:0] w_dy;
    logic signed [9:0] w_adx;
    logic signed [9:0] w_ady;
    logic signed [1:0] w_sx;
    logic signed [1:0] w_sy;
    logic signed [11:0] w_err_init;
    logic signed [12:0] w_e2;
    logic signed [12:0] w_adx13;
    logic signed [12:0] w_ady13;
    logic              w_step_x;
    logic              w_step_y;
    logic signed [11:0] w_err_next;
    logic [8:0]        w_x_next;
    logic [7:0]        w_y_next;

    assign pos_ready = (r_state == S_IDLE);
    assign busy      = (r_state == S_LINE);
    assign vga_x     = r_vga_x;
    assign vga_y     = r_vga_y;
    assign vga_color = r_vga_color;
    assign vga_write = r_vga_write;

    assign w_accept     = pos_valid && pos_ready;
    assign w_clamp_x    = (pos_x > MAX_X) ? MAX_X : pos_x;
    assign w_clamp_y    = (pos_y > MAX_Y) ? MAX_Y : pos_y;
    assign w_same_point = (w_clamp_x == r_last_x) && (w_clamp_y == r_last_y);
    assign w_start_line = w_accept && pen_down && r_last_valid && !w_same_point;
    // The endpoint is the stored last point, which is updated at acceptance.
    assign w_at_end     = (r_vga_x == r_last_x) && (r_vga_y == r_last_y);

    assign w_dx  = $signed({1'b0, w_clamp_x}) - $signed({1'b0, r_last_x});
    assign w_dy  = $signed({2'b00, w_clamp_y}) - $signed({2'b00, r_last_y});
    assign w_adx = w_dx[9] ? -w_dx : w_dx;
    assign w_ady = w_dy[9] ? -w_dy : w_dy;
    assign w_sx  = w_dx[9] ? 2'sb11 : ((w_dx != 10'sd0) ? 2'sb01 : 2'sb00);
    assign w_sy  = w_dy[9] ? 2'sb11 : ((w_dy != 10'sd0) ? 2'sb01 : 2'sb00);
    assign w_err_init = $signed({2'b00, w_adx}) - $signed({2'b00, w_ady});

    assign w_e2     = $signed({r_err, 1'b0});
    assign w_adx13  = $signed({3'b000, r_adx});
    assign w_ady13  = $signed({3'b000, r_ady});
    assign w_step_x = (w_e2 >= -w_ady13);
    assign w_step_y = (w_e2 <= w_adx13);
    assign w_err_next = r_err
                      - (w_step_x ? $signed({2'b00, r_ady}) : 12'sd0)
                      + (w_step_y ? $signed({2'b00, r_adx}) : 12'sd0);
    // Modular add of a sign-extended -1/0/+1 step.
    assign w_x_next = w_step_x ? (r_vga_x + {{7{r_sx[1]}}, r_sx}) : r_vga_x;
    assign w_y_next = w_step_y ? (r_vga_y + {{6{r_sy[1]}}, r_sy}) : r_vga_y;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_line) begin
                    w_state_next = S_LINE;
                end
            end
            S_LINE: begin
                if (w_at_end) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_last_x     <= '0;
            r_last_y     <= '0;
            r_last_valid <= 1'b0;
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_vga_color  <= '0;
            r_vga_write  <= 1'b0;
            r_adx        <= '0;
            r_ady        <= '0;
            r_sx         <= '0;
            r_sy         <= '0;
            r_err        <= '0;
        end else begin
            r_vga_write <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_last_x     <= w_clamp_x;
                        r_last_y     <= w_clamp_y;
                        r_last_valid <= pen_down;
                        if (pen_down) begin
                            r_vga_write <= 1'b1;
                            r_vga_color <= pen_color;
                            // A line starts by writing the old endpoint.
                            if (r_last_valid) begin
                                r_vga_x <= r_last_x;
                                r_vga_y <= r_last_y;
                            end else begin
                                r_vga_x <= w_clamp_x;
                                r_vga_y <= w_clamp_y;
                            end
                            r_adx <= w_adx;
                            r_ady <= w_ady;
                            r_sx  <= w_sx;
                            r_sy  <= w_sy;
                            r_err <= w_err_init;
                        end
                    end
                end
                S_LINE: begin
                    if (!w_at_end) begin
                        r_vga_write <= 1'b1;
                        r_vga_x     <= w_x_next;
                        r_vga_y     <= w_y_next;
                        r_err       <= w_err_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
